// File: rtl/scan_mux_pkg.sv
// -----------------------------------------------------------------------------
// scan_mux_pkg
//
// Shared definitions for the scan_mux channel selector:
//   - mode_e        : operating mode (manual select or round-robin scan)
//   - sel_width()   : channel/counter index width, never below one bit
//   - DEFAULT_DWELL : default number of cycles spent on each scanned channel
//
// Optional feature macro used by this block: SCAN_MUX_SKIP_EN
// -----------------------------------------------------------------------------
package scan_mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    localparam int DEFAULT_DWELL = 8;

    // $clog2 with a floor of one bit, so a value range of 1 still gets a
    // legal vector width.
    function automatic int sel_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : scan_mux_pkg

// File: rtl/scan_mux_next.sv
// -----------------------------------------------------------------------------
// scan_mux_next
//
// Combinational next-channel finder for the scan sequencer. Starting just
// after the current channel and moving circularly, it returns the first
// channel whose mask bit is set. With an all-ones mask this reduces to
// (cur_sel + 1) mod CHANNELS.
//
// Ports:
//   cur_sel_i   in   SELW      channel currently selected
//   mask_i      in   CHANNELS  per-channel scan enable
//   next_sel_o  out  SELW      channel to select at the end of the dwell
//   wraps_o     out  1         new index <= old index (scan wrapped around)
//
// If no mask bit is set the current channel is returned and wraps_o stays 0.
// A single set bit returns that same channel, which counts as a wrap.
// -----------------------------------------------------------------------------
module scan_mux_next
    import scan_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SELW     = sel_width(CHANNELS)
) (
    input  logic [SELW-1:0]     cur_sel_i,
    input  logic [CHANNELS-1:0] mask_i,
    output logic [SELW-1:0]     next_sel_o,
    output logic                wraps_o
);

    int              cand;
    logic [SELW-1:0] cand_sel;
    logic            found;

    // NOTE: every variable written here gets a default before the loop, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        next_sel_o = cur_sel_i;
        wraps_o    = 1'b0;
        found      = 1'b0;
        cand       = 0;
        cand_sel   = '0;
        // k = CHANNELS visits cur_sel itself last, which covers the
        // single-bit-mask case.
        for (int k = 1; k <= CHANNELS; k++) begin
            cand = int'(cur_sel_i) + k;
            if (cand >= CHANNELS) begin
                cand = cand - CHANNELS;
            end
            cand_sel = SELW'(cand);
            if (!found && mask_i[cand_sel]) begin
                found      = 1'b1;
                next_sel_o = cand_sel;
                wraps_o    = (cand <= int'(cur_sel_i));
            end
        end
    end

endmodule : scan_mux_next

// File: rtl/scan_mux.sv
// -----------------------------------------------------------------------------
// scan_mux
//
// Registered N-channel selector with channel tagging. In manual mode the
// external select picks the channel. In scan mode a dwell counter steps
// through the channels round-robin. All outputs are registered.
//
// Parameters:
//   CHANNELS  number of input channels (>= 2)
//   WIDTH     bits per channel
//   DWELL     cycles spent on each channel in scan mode (>= 1)
//   SELW      select width, derived from CHANNELS
//
// Ports:
//   clk        in   1               rising-edge clock
//   reset      in   1               synchronous, active-high reset
//   in_data    in   CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
//   sel        in   SELW            manual channel select
//   auto_en    in   1               1 = scan mode, 0 = manual mode
//   hold       in   1               freezes counter and channel in scan mode
//   ch_mask    in   CHANNELS        per-channel scan enable (SCAN_MUX_SKIP_EN)
//   out        out  WIDTH           registered selected data
//   out_ch     out  SELW            channel index that produced out
//   out_valid  out  1               out holds real data
//   cur_sel    out  SELW            channel currently being selected
//   wrap       out  1               pulse when the scan returns to a lower index
//   sel_err    out  1               pulse on an out-of-range manual select
//
// Optional feature macro: SCAN_MUX_SKIP_EN adds ch_mask. The scan then skips
// channels whose mask bit is 0. Without the macro every channel is scanned.
// -----------------------------------------------------------------------------
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int WIDTH    = 1,
    parameter  int DWELL    = DEFAULT_DWELL,
    localparam int SELW     = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]           sel,
    input  logic                      auto_en,
    input  logic                      hold,
`ifdef SCAN_MUX_SKIP_EN
    input  logic [CHANNELS-1:0]       ch_mask,
`endif
    output logic [WIDTH-1:0]          out,
    output logic [SELW-1:0]           out_ch,
    output logic                      out_valid,
    output logic [SELW-1:0]           cur_sel,
    output logic                      wrap,
    output logic                      sel_err
);

    localparam int              CNTW     = sel_width(DWELL);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    mode_e            mode_q,      mode_d;
    logic [CNTW-1:0]  cnt_q,       cnt_d;
    logic [SELW-1:0]  cur_sel_q,   cur_sel_d;
    logic [WIDTH-1:0] out_q,       out_d;
    logic [SELW-1:0]  out_ch_q;
    logic             out_valid_q;
    logic             wrap_q,      wrap_d;
    logic             sel_err_q,   sel_err_d;

    // -------------------------------------------------------------------------
    // Channel unpacking
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] chan [CHANNELS];

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        assign chan[k] = in_data[k*WIDTH +: WIDTH];
    end

    // -------------------------------------------------------------------------
    // Next-channel finder
    // -------------------------------------------------------------------------
    logic [CHANNELS-1:0] scan_mask;
    logic [SELW-1:0]     next_sel;
    logic                next_wraps;

`ifdef SCAN_MUX_SKIP_EN
    assign scan_mask = ch_mask;
`else
    assign scan_mask = '1;
`endif

    scan_mux_next #(
        .CHANNELS (CHANNELS),
        .SELW     (SELW)
    ) u_next (
        .cur_sel_i  (cur_sel_q),
        .mask_i     (scan_mask),
        .next_sel_o (next_sel),
        .wraps_o    (next_wraps)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // The mode tracks auto_en with one cycle of delay. Work done this
        // cycle is decided by the registered mode, so the edge that leaves
        // SCAN still completes a scan step.
        mode_d    = auto_en ? MODE_SCAN : MODE_MANUAL;
        cnt_d     = cnt_q;
        cur_sel_d = cur_sel_q;
        wrap_d    = 1'b0;
        sel_err_d = 1'b0;

        unique case (mode_q)
            MODE_MANUAL: begin
                // The counter is held at 0, so a later entry into SCAN
                // always starts a full dwell on the current channel.
                cnt_d = '0;
                if (int'(sel) < CHANNELS) begin
                    cur_sel_d = sel;
                end else begin
                    sel_err_d = 1'b1;
                end
            end
            MODE_SCAN: begin
                if (!hold) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        cur_sel_d = next_sel;
                        wrap_d    = next_wraps;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase

        // The datapath always uses the registered channel, so out and out_ch
        // lag cur_sel by exactly one cycle and always agree with each other.
        out_d = chan[cur_sel_q];
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples pre-edge values, whatever order the statements
    // are written in.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q      <= MODE_MANUAL;
            cnt_q       <= '0;
            cur_sel_q   <= '0;
            out_q       <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            cur_sel_q   <= cur_sel_d;
            out_q       <= out_d;
            out_ch_q    <= cur_sel_q;
            out_valid_q <= 1'b1;
            wrap_q      <= wrap_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out       = out_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign cur_sel   = cur_sel_q;
    assign wrap      = wrap_q;
    assign sel_err   = sel_err_q;

endmodule : scan_mux
